// File: rtl/wave_osc.sv
// rtl/wave_osc.sv - multi-waveform phase-accumulator oscillator
// Square, saw, triangle and pulse outputs; mode/duty switch only at wrap or hard sync.
module wave_osc #(
  parameter int WIDTH      = 24,
  parameter int DUTY_WIDTH = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  tick_in,
  input  logic [WIDTH-1:0]      phase_incr_in,
  input  logic [1:0]            mode_in,
  input  logic [DUTY_WIDTH-1:0] duty_in,
  input  logic                  sync_in,
  output logic [WIDTH-1:0]      val_out,
  output logic                  valid_out,
  output logic                  wrap_out
);

  localparam logic [1:0] MODE_SQUARE = 2'd0;
  localparam logic [1:0] MODE_SAW    = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;
  localparam logic [1:0] MODE_PULSE  = 2'd3;

  localparam logic [WIDTH-1:0] HALF    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] VAL_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] VAL_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0]      phase_q, phase_d;
  logic [1:0]            act_mode_q, act_mode_d;
  logic [DUTY_WIDTH-1:0] act_duty_q, act_duty_d;
  logic                  armed_q, armed_d;
  logic                  pend_q, pend_d;
  logic                  pend_wrap_q, pend_wrap_d;
  logic [WIDTH-1:0]      val_q, val_d;
  logic                  valid_q, valid_d;
  logic                  wrap_q, wrap_d;

  logic [WIDTH:0]        sum;
  logic                  carry;
  logic                  load;
  logic [WIDTH-2:0]      tri_mag;
  logic [WIDTH-1:0]      wave;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      phase_q     <= '0;
      act_mode_q  <= MODE_SQUARE;
      act_duty_q  <= '0;
      armed_q     <= 1'b1;
      pend_q      <= 1'b0;
      pend_wrap_q <= 1'b0;
      val_q       <= '0;
      valid_q     <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      act_mode_q  <= act_mode_d;
      act_duty_q  <= act_duty_d;
      armed_q     <= armed_d;
      pend_q      <= pend_d;
      pend_wrap_q <= pend_wrap_d;
      val_q       <= val_d;
      valid_q     <= valid_d;
      wrap_q      <= wrap_d;
    end
  end

  // Phase update: sync beats tick; the carry out of the add marks a wrap.
  always_comb begin
    phase_d = phase_q;
    carry   = 1'b0;
    sum     = {1'b0, phase_q} + {1'b0, phase_incr_in};
    if (sync_in) begin
      phase_d = '0;
    end else if (tick_in) begin
      phase_d = sum[WIDTH-1:0];
      carry   = sum[WIDTH];
    end
  end

  // New mode/duty is captured together with the phase it applies to.
  always_comb begin
    load        = sync_in | (tick_in & (carry | armed_q));
    act_mode_d  = load ? mode_in : act_mode_q;
    act_duty_d  = load ? duty_in : act_duty_q;
    armed_d     = armed_q & ~load;
    pend_d      = sync_in | tick_in;
    pend_wrap_d = carry;
  end

  always_comb begin
    wave    = '0;
    tri_mag = phase_q[WIDTH-1] ? ~phase_q[WIDTH-2:0] : phase_q[WIDTH-2:0];
    case (act_mode_q)
      MODE_SQUARE: wave = phase_q[WIDTH-1] ? VAL_MIN : VAL_MAX;
      MODE_SAW:    wave = phase_q ^ HALF;
      MODE_TRI:    wave = {tri_mag, 1'b0} - HALF;
      MODE_PULSE:  wave = (phase_q[WIDTH-1 -: DUTY_WIDTH] < act_duty_q) ? VAL_MAX : VAL_MIN;
      default:     wave = '0;
    endcase
  end

  always_comb begin
    val_d   = pend_q ? wave : val_q;
    valid_d = pend_q;
    wrap_d  = pend_q & pend_wrap_q;
  end

  assign val_out   = val_q;
  assign valid_out = valid_q;
  assign wrap_out  = wrap_q;

endmodule

// File: tb/tb_wave_osc.sv
// tb/tb_wave_osc.sv - scoreboard bench for wave_osc
// Expected samples are queued as stimulus is driven and popped when valid_out fires.
module tb_wave_osc;

  localparam logic [23:0] MAX = 24'h7FFFFF;
  localparam logic [23:0] MIN = 24'h800000;

  typedef struct {
    logic [23:0] val;
    logic        wrap;
    longint      due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic        sync = 1'b0;
  logic [23:0] incr_i = '0;
  logic [1:0]  mode_i = '0;
  logic [7:0]  duty_i = '0;
  logic [23:0] val_out;
  logic        valid_out;
  logic        wrap_out;

  int checks = 0;
  int errors = 0;
  int vcount = 0;
  exp_t q[$];

  logic [23:0] m_phase = '0;
  logic [1:0]  m_mode = '0;
  logic [7:0]  m_duty = '0;
  bit          m_armed = 1'b1;

  wave_osc #(.WIDTH(24), .DUTY_WIDTH(8)) dut (
    .clk_in(clk), .rst_in(rst), .tick_in(tick), .phase_incr_in(incr_i),
    .mode_in(mode_i), .duty_in(duty_i), .sync_in(sync),
    .val_out(val_out), .valid_out(valid_out), .wrap_out(wrap_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] model_f();
    int tv;
    case (m_mode)
      2'd0: return (m_phase >= 24'h800000) ? MIN : MAX;
      2'd1: return m_phase - 24'h800000;
      2'd2: begin
        if (m_phase < 24'h800000) tv = int'(m_phase);
        else tv = int'(24'hFFFFFF - m_phase);
        return 24'(2 * tv - 32'sh800000);
      end
      default: return ((m_phase >> 16) < {16'd0, m_duty}) ? MAX : MIN;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = '0; m_mode = '0; m_duty = '0; m_armed = 1'b1;
  endtask

  // One clock of stimulus; use_c selects a literal expected sample over the model's.
  task automatic step(input bit t, input bit s, input logic [23:0] incr, input logic [1:0] m,
                      input logic [7:0] d, input bit use_c, input logic [23:0] cv, input bit cw);
    exp_t e;
    logic [24:0] total;
    bit carry;
    bit ld;
    @(negedge clk);
    tick = t; sync = s; incr_i = incr; mode_i = m; duty_i = d;
    carry = 1'b0;
    if (s) m_phase = '0;
    else if (t) begin
      total = {1'b0, m_phase} + {1'b0, incr};
      carry = total[24];
      m_phase = total[23:0];
    end
    ld = s || (t && (carry || m_armed));
    if (ld) begin m_mode = m; m_duty = d; m_armed = 1'b0; end
    if (t || s) begin
      e.val  = use_c ? cv : model_f();
      e.wrap = use_c ? cw : carry;
      e.due  = longint'($time) + 20;
      q.push_back(e);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, incr_i, mode_i, duty_i, 1'b0, '0, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t me;
    if (!rst) begin
      if (valid_out) begin
        vcount++;
        if (q.size() == 0) chk("unexpected_valid", 1, 0);
        else begin
          me = q.pop_front();
          chk("val", {40'd0, val_out}, {40'd0, me.val});
          chk("wrap", {63'd0, wrap_out}, {63'd0, me.wrap});
          chk("valid_time", $time, me.due);
        end
      end else begin
        chk("wrap_without_valid", {63'd0, wrap_out}, 0);
        if (q.size() > 0 && q[0].due <= longint'($time)) begin
          chk("missing_valid", 0, 1);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [23:0] sq_tab [8];
    logic [23:0] saw_tab [8];
    logic [23:0] sw_tab [9];
    logic [23:0] pl_tab [8];
    int vstart;
    sq_tab  = '{MAX, MAX, MAX, MIN, MIN, MIN, MIN, MAX};
    saw_tab = '{24'hA00000, 24'hC00000, 24'hE00000, 24'h000000,
                24'h200000, 24'h400000, 24'h600000, 24'h800000};
    sw_tab  = '{MAX, MAX, MAX, MIN, MIN, MIN, MIN, 24'h800000, 24'hC00000};
    pl_tab  = '{MAX, MIN, MIN, MIN, MIN, MIN, MIN, MAX};

    #3 rst = 1'b1;
    #1;
    chk("reset_val", {40'd0, val_out}, 0);
    chk("reset_valid", {63'd0, valid_out}, 0);
    chk("reset_wrap", {63'd0, wrap_out}, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();

    for (int i = 0; i < 8; i++)
      step(1, 0, 24'h200000, 2'd0, 8'h00, 1, sq_tab[i], i == 7);

    step(0, 1, 24'h200000, 2'd1, 8'h00, 1, 24'h800000, 0);
    for (int i = 0; i < 8; i++)
      step(1, 0, 24'h200000, 2'd1, 8'h00, 1, saw_tab[i], i == 7);

    step(0, 1, 24'h200000, 2'd0, 8'h00, 1, MAX, 0);
    for (int i = 0; i < 9; i++)
      step(1, 0, 24'h200000, (i < 2) ? 2'd0 : 2'd2, 8'h00, 1, sw_tab[i], i == 7);

    step(0, 1, 24'h200000, 2'd3, 8'h40, 1, MAX, 0);
    for (int i = 0; i < 8; i++)
      step(1, 0, 24'h200000, 2'd3, 8'h40, 1, pl_tab[i], i == 7);
    step(0, 1, 24'h200000, 2'd3, 8'h00, 1, MIN, 0);
    for (int i = 0; i < 8; i++)
      step(1, 0, 24'h200000, 2'd3, 8'h00, 1, MIN, i == 7);

    step(0, 1, 24'h200000, 2'd0, 8'h00, 0, '0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 24'h200000, 2'd0, 8'h00, 0, '0, 0);
    vstart = vcount + int'(q.size());
    step(0, 1, 24'h200000, 2'd0, 8'h00, 1, MAX, 0);
    for (int i = 0; i < 5; i++) idle();
    #1;
    chk("idle_valids", vcount - vstart, 1);
    step(1, 0, 24'h200000, 2'd0, 8'h00, 1, MAX, 0);

    step(1, 1, 24'h350000, 2'd1, 8'h00, 1, 24'h800000, 0);
    step(1, 0, 24'h000000, 2'd1, 8'h00, 1, 24'h800000, 0);
    step(1, 0, 24'h000000, 2'd1, 8'h00, 1, 24'h800000, 0);
    step(1, 0, 24'h123457, 2'd2, 8'h00, 0, '0, 0);

    for (int i = 0; i < 60; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, 24'($urandom),
           2'($urandom_range(0, 3)), 8'($urandom), 0, '0, 0);

    for (int i = 0; i < 4; i++) step(1, 0, 24'h300000, 2'd1, 8'h00, 0, '0, 0);
    @(negedge clk);
    #2 rst = 1'b1; tick = 1'b0; sync = 1'b0;
    q.delete();
    model_reset();
    #1;
    chk("midrst_val", {40'd0, val_out}, 0);
    chk("midrst_valid", {63'd0, valid_out}, 0);
    chk("midrst_wrap", {63'd0, wrap_out}, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    step(1, 0, 24'h200000, 2'd1, 8'h00, 1, 24'hA00000, 0);
    step(1, 0, 24'h200000, 2'd1, 8'h00, 1, 24'hC00000, 0);
    idle();

    for (int i = 0; i < 6 && q.size() > 0; i++) @(negedge clk);
    #1;
    chk("drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
